// File: rtl/hd44780_rx.sv
// hd44780_rx: receive side of the HD44780 4-bit character-LCD bus.
// Synchronises rs/en/data, assembles nibbles into bytes, decodes the LCD command set and keeps
// an 80-byte DDRAM image with a registered read port.
// Optional feature: define LCDRX_NIB_TIMEOUT_EN to build the hi/lo nibble timeout.
module hd44780_rx #(
   parameter int unsigned EN_MIN_CYC  = 8,
   parameter int unsigned CLEAR_CYC   = 80,
   parameter int unsigned NIB_TIMEOUT = 65535
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       lcd_rs,
   input  logic       lcd_en,
   input  logic [3:0] lcd_data,
   input  logic [6:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       byte_valid,
   output logic [7:0] byte_out,
   output logic       byte_is_dat,
   output logic [6:0] cur_addr,
   output logic       disp_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       entry_inc,
   output logic       entry_shift,
   output logic       if_4bit,
   output logic       two_line,
   output logic       busy,
   output logic       err
);

   localparam int unsigned DEPTH = 80;
   localparam int unsigned HW    = $clog2(EN_MIN_CYC + 1);
   localparam int unsigned BW    = $clog2(CLEAR_CYC + 1);

   typedef enum logic [1:0] {PhMode8, PhMode4Hi, PhMode4Lo} phase_e;

   logic          rs_m, rs_s, en_m, en_s;
   logic [3:0]    data_m, data_s;
   logic          rs_h;
   logic [3:0]    data_h;
   logic [HW-1:0] hi_cnt;
   phase_e        phase;
   logic [3:0]    hi_nib;
   logic [BW-1:0] busy_cnt;
   logic          fill_on;
   logic [6:0]    fill_idx;
   logic [7:0]    ddram [DEPTH];

   logic          nib_fall, byte_done;
   logic [7:0]    byte_new;
   logic          wr_en;
   logic [6:0]    wr_idx;
   logic [7:0]    wr_val;

`ifdef LCDRX_NIB_TIMEOUT_EN
   localparam int unsigned TW = $clog2(NIB_TIMEOUT + 1);
   logic [TW-1:0] to_cnt;
`endif

   // Address counter step with the HD44780 two-line wrap points.
   function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
      if (inc) begin
         if (a == 7'h27) return 7'h40;
         else if (a == 7'h67) return 7'h00;
         else return a + 7'd1;
      end else begin
         if (a == 7'h00) return 7'h67;
         else if (a == 7'h40) return 7'h27;
         else return a - 7'd1;
      end
   endfunction

   // Columns 40..63 of either line do not exist; snap them to the line start.
   function automatic logic [6:0] addr_legal(input logic [6:0] a);
      if (a[5:0] >= 6'd40) return {a[6], 6'd0};
      else return a;
   endfunction

   function automatic logic [6:0] addr_idx(input logic [6:0] a);
      return a[6] ? 7'd40 + {1'b0, a[5:0]} : {1'b0, a[5:0]};
   endfunction

   // Two-flop synchronisers on the asynchronous LCD bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs_m   <= 1'b0;
         rs_s   <= 1'b0;
         en_m   <= 1'b0;
         en_s   <= 1'b0;
         data_m <= 4'h0;
         data_s <= 4'h0;
      end else begin
         rs_m   <= lcd_rs;
         rs_s   <= rs_m;
         en_m   <= lcd_en;
         en_s   <= en_m;
         data_m <= lcd_data;
         data_s <= data_m;
      end
   end

   // Measure the en high time and hold the bus value seen while en was high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_cnt <= '0;
         rs_h   <= 1'b0;
         data_h <= 4'h0;
      end else begin
         if (!en_s) hi_cnt <= '0;
         else if (hi_cnt != HW'(EN_MIN_CYC)) hi_cnt <= hi_cnt + 1'b1;
         if (en_s) begin
            rs_h   <= rs_s;
            data_h <= data_s;
         end
      end
   end

   // Qualified falling edge and byte assembly.
   always_comb begin
      nib_fall  = !en_s && (hi_cnt == HW'(EN_MIN_CYC));
      byte_done = 1'b0;
      byte_new  = {data_h, 4'h0};
      if (nib_fall) begin
         case (phase)
            PhMode8:   byte_done = 1'b1;
            PhMode4Lo: begin
               byte_done = 1'b1;
               byte_new  = {hi_nib, data_h};
            end
            default:   byte_done = 1'b0;
         endcase
      end
   end

   // Single DDRAM write port: clear fill has priority over data writes.
   always_comb begin
      wr_en  = 1'b0;
      wr_idx = fill_idx;
      wr_val = 8'h20;
      if (fill_on) begin
         wr_en = 1'b1;
      end else if (byte_done && !busy && rs_h) begin
         wr_en  = 1'b1;
         wr_idx = addr_idx(cur_addr);
         wr_val = byte_new;
      end
   end

   // DDRAM image storage, deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) ddram[wr_idx] <= wr_val;
   end

   // Registered read port, independent of the write side.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data <= 8'h00;
      else rd_data <= (rd_addr < 7'd80) ? ddram[rd_addr] : 8'h00;
   end

   // Phase FSM, command decode, busy timing and clear fill sequencing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase       <= PhMode8;
         hi_nib      <= 4'h0;
         byte_valid  <= 1'b0;
         byte_out    <= 8'h00;
         byte_is_dat <= 1'b0;
         err         <= 1'b0;
         cur_addr    <= 7'h00;
         disp_on     <= 1'b0;
         cursor_on   <= 1'b0;
         blink_on    <= 1'b0;
         entry_inc   <= 1'b1;
         entry_shift <= 1'b0;
         if_4bit     <= 1'b0;
         two_line    <= 1'b0;
         busy        <= 1'b0;
         busy_cnt    <= '0;
         fill_on     <= 1'b0;
         fill_idx    <= 7'd0;
`ifdef LCDRX_NIB_TIMEOUT_EN
         to_cnt      <= '0;
`endif
      end else begin
         byte_valid <= 1'b0;
         err        <= 1'b0;
         if (busy) begin
            if (busy_cnt == '0) busy <= 1'b0;
            else busy_cnt <= busy_cnt - 1'b1;
         end
         if (fill_on) begin
            if (fill_idx == 7'(DEPTH - 1)) fill_on <= 1'b0;
            else fill_idx <= fill_idx + 7'd1;
         end
         if (nib_fall) begin
            case (phase)
               PhMode4Hi: begin
                  hi_nib <= data_h;
                  phase  <= PhMode4Lo;
               end
               PhMode4Lo: phase <= PhMode4Hi;
               default:   phase <= PhMode8;
            endcase
         end
`ifdef LCDRX_NIB_TIMEOUT_EN
         if (phase != PhMode4Lo || nib_fall) begin
            to_cnt <= '0;
         end else if (to_cnt == TW'(NIB_TIMEOUT)) begin
            to_cnt <= '0;
            phase  <= PhMode4Hi;
            err    <= 1'b1;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end
`endif
         if (byte_done) begin
            byte_valid  <= 1'b1;
            byte_out    <= byte_new;
            byte_is_dat <= rs_h;
            if (busy) begin
               err <= 1'b1;
            end else if (rs_h) begin
               cur_addr <= addr_step(cur_addr, entry_inc);
            end else if (byte_new[7]) begin
               cur_addr <= addr_legal(byte_new[6:0]);
            end else if (byte_new[6]) begin
               // CGRAM address: not mirrored.
            end else if (byte_new[5]) begin
               if_4bit  <= !byte_new[4];
               two_line <= byte_new[3];
               phase    <= byte_new[4] ? PhMode8 : PhMode4Hi;
            end else if (byte_new[4]) begin
               // Cursor/display shift: no effect on the image.
            end else if (byte_new[3]) begin
               disp_on   <= byte_new[2];
               cursor_on <= byte_new[1];
               blink_on  <= byte_new[0];
            end else if (byte_new[2]) begin
               entry_inc   <= byte_new[1];
               entry_shift <= byte_new[0];
            end else if (byte_new[1]) begin
               cur_addr <= 7'h00;
               busy     <= 1'b1;
               busy_cnt <= BW'(1);
            end else if (byte_new[0]) begin
               cur_addr  <= 7'h00;
               entry_inc <= 1'b1;
               busy      <= 1'b1;
               busy_cnt  <= BW'(CLEAR_CYC - 1);
               fill_on   <= 1'b1;
               fill_idx  <= 7'd0;
            end
         end
      end
   end

endmodule

// File: tb/tb_hd44780_rx.sv
// tb_hd44780_rx: randomised bench for hd44780_rx against a byte/nibble-level LCD model.
module tb_hd44780_rx;

   localparam int unsigned EN_MIN_CYC  = 8;
   localparam int unsigned CLEAR_CYC   = 80;
   localparam int unsigned NIB_TIMEOUT = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       lcd_rs = 1'b0;
   logic       lcd_en = 1'b0;
   logic [3:0] lcd_data = 4'h0;
   logic [6:0] rd_addr = 7'd0;
   logic [7:0] rd_data, byte_out;
   logic       byte_valid, byte_is_dat, disp_on, cursor_on, blink_on, entry_inc, entry_shift;
   logic       if_4bit, two_line, busy, err;
   logic [6:0] cur_addr;

   always #5 clk = ~clk;

   hd44780_rx #(
      .EN_MIN_CYC (EN_MIN_CYC),
      .CLEAR_CYC  (CLEAR_CYC),
      .NIB_TIMEOUT(NIB_TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lcd_rs     (lcd_rs),
      .lcd_en     (lcd_en),
      .lcd_data   (lcd_data),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .byte_valid (byte_valid),
      .byte_out   (byte_out),
      .byte_is_dat(byte_is_dat),
      .cur_addr   (cur_addr),
      .disp_on    (disp_on),
      .cursor_on  (cursor_on),
      .blink_on   (blink_on),
      .entry_inc  (entry_inc),
      .entry_shift(entry_shift),
      .if_4bit    (if_4bit),
      .two_line   (two_line),
      .busy       (busy),
      .err        (err)
   );

   int n_chk = 0;
   int n_fail = 0;

   // Observed byte stream, error pulses and busy run lengths.
   logic [8:0] got_q[$];
   int err_seen = 0;
   int busy_run = 0;
   int busy_len = 0;
   always @(negedge clk) begin
      if (byte_valid) got_q.push_back({byte_is_dat, byte_out});
      if (err) err_seen++;
      if (busy) busy_run++;
      else if (busy_run != 0) begin
         busy_len = busy_run;
         busy_run = 0;
      end
   end

   // Reference model: display as (line, column), DDRAM as a plain array.
   logic [7:0] m_mem [80];
   bit         m_known [80];
   int         m_line, m_col, m_phase, m_err, m_busy_len;
   bit         m_inc, m_shift, m_disp, m_cur, m_blink, m_4bit, m_2line, m_busy;
   logic [3:0] m_hi;
   logic [8:0] exp_q[$];

   function automatic logic [6:0] m_addr();
      return 7'(m_line * 64 + m_col);
   endfunction

   function automatic logic [6:0] m_modes();
      return {m_disp, m_cur, m_blink, m_inc, m_shift, m_4bit, m_2line};
   endfunction

   task automatic m_reset();
      m_line = 0; m_col = 0; m_phase = 0; m_inc = 1; m_shift = 0;
      m_disp = 0; m_cur = 0; m_blink = 0; m_4bit = 0; m_2line = 0; m_busy = 0;
   endtask

   task automatic m_byte(input logic rs, input logic [7:0] b);
      exp_q.push_back({rs, b});
      if (m_busy) begin
         m_err++;
      end else if (rs) begin
         m_mem[m_line * 40 + m_col] = b;
         m_known[m_line * 40 + m_col] = 1;
         if (m_inc) begin
            m_col++;
            if (m_col == 40) begin m_col = 0; m_line = 1 - m_line; end
         end else if (m_col == 0) begin
            m_col = 39; m_line = 1 - m_line;
         end else begin
            m_col--;
         end
      end else if (b[7]) begin
         m_line = b[6] ? 1 : 0;
         m_col = int'(b[5:0]);
         if (m_col >= 40) m_col = 0;
      end else if (b[6]) begin
      end else if (b[5]) begin
         m_4bit = !b[4]; m_2line = b[3]; m_phase = b[4] ? 0 : 1;
      end else if (b[4]) begin
      end else if (b[3]) begin
         m_disp = b[2]; m_cur = b[1]; m_blink = b[0];
      end else if (b[2]) begin
         m_inc = b[1]; m_shift = b[0];
      end else if (b[1]) begin
         m_line = 0; m_col = 0; m_busy = 1; m_busy_len = 2;
      end else if (b[0]) begin
         m_line = 0; m_col = 0; m_inc = 1; m_busy = 1; m_busy_len = CLEAR_CYC;
         for (int i = 0; i < 80; i++) begin m_mem[i] = 8'h20; m_known[i] = 1; end
      end
   endtask

   task automatic m_nib(input logic rs, input logic [3:0] n);
      if (m_phase == 0) begin
         m_byte(rs, {n, 4'h0});
      end else if (m_phase == 1) begin
         m_hi = n; m_phase = 2;
      end else begin
         m_phase = 1;
         m_byte(rs, {m_hi, n});
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic send_nib(input logic rs, input logic [3:0] n, input int hi_len);
      lcd_rs = rs; lcd_data = n; lcd_en = 1'b1;
      tick(hi_len);
      lcd_en = 1'b0;
      if (hi_len >= int'(EN_MIN_CYC)) m_nib(rs, n);
      tick(6);
   endtask

   task automatic send_byte(input logic rs, input logic [7:0] b);
      if (m_phase == 0) begin
         send_nib(rs, b[7:4], $urandom_range(EN_MIN_CYC, EN_MIN_CYC + 6));
      end else begin
         send_nib(rs, b[7:4], $urandom_range(EN_MIN_CYC, EN_MIN_CYC + 6));
         send_nib(rs, b[3:0], $urandom_range(EN_MIN_CYC, EN_MIN_CYC + 6));
      end
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 300 && busy; i++) tick(1);
      tick(1);
      n_chk++;
      if (busy) begin
         n_fail++;
         $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, i);
      end
      m_busy = 0;
   endtask

   task automatic read_mem(input int idx, output logic [7:0] v);
      rd_addr = 7'(idx);
      tick(1);
      v = rd_data;
   endtask

   task automatic test_reset();
      m_reset();
      m_err = 0;
      for (int i = 0; i < 80; i++) m_known[i] = 0;
      rst_n = 1'b0;
      tick(3);
      n_chk++;
      if (rd_data !== 8'h00) begin
         n_fail++; $display("FAIL reset_rd_data: got %h required 00", rd_data);
      end
      rst_n = 1'b1;
      tick(2);
      n_chk++;
      if ({disp_on, cursor_on, blink_on, entry_inc, entry_shift, if_4bit, two_line} !== m_modes())
      begin
         n_fail++;
         $display("FAIL reset_modes: got %b required %b",
                  {disp_on, cursor_on, blink_on, entry_inc, entry_shift, if_4bit, two_line},
                  m_modes());
      end
      n_chk++;
      if (cur_addr !== 7'h00) begin
         n_fail++; $display("FAIL reset_cur_addr: got %h required 00", cur_addr);
      end
      n_chk++;
      if ({busy, byte_valid, byte_is_dat, err} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b required 0000", {busy, byte_valid, byte_is_dat, err});
      end
      n_chk++;
      if (byte_out !== 8'h00) begin
         n_fail++; $display("FAIL reset_byte_out: got %h required 00", byte_out);
      end
   endtask

   task automatic test_init();
      logic [7:0] v;
      got_q.delete(); exp_q.delete();
      send_nib(0, 4'h3, 10);
      send_nib(0, 4'h3, 10);
      send_nib(0, 4'h3, 10);
      send_nib(0, 4'h2, 10);
      send_byte(0, 8'h28);
      send_byte(0, 8'h0C);
      send_byte(0, 8'h06);
      busy_len = 0;
      send_byte(0, 8'h01);
      wait_idle();
      n_chk++;
      if (busy_len != int'(CLEAR_CYC)) begin
         n_fail++; $display("FAIL init_clear_busy_len: got %0d required %0d", busy_len, CLEAR_CYC);
      end
      send_byte(0, 8'h80);
      n_chk++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL init_byte_count: got %0d required %0d", got_q.size(), exp_q.size());
      end else begin
         for (int k = 0; k < exp_q.size(); k++) begin
            n_chk++;
            if (got_q[k] !== exp_q[k]) begin
               n_fail++; $display("FAIL init_byte[%0d]: got %h required %h", k, got_q[k], exp_q[k]);
            end
         end
      end
      n_chk++;
      if ({disp_on, cursor_on, blink_on, entry_inc, entry_shift, if_4bit, two_line} !== m_modes())
      begin
         n_fail++;
         $display("FAIL init_modes: got %b required %b",
                  {disp_on, cursor_on, blink_on, entry_inc, entry_shift, if_4bit, two_line},
                  m_modes());
      end
      n_chk++;
      if (cur_addr !== m_addr()) begin
         n_fail++; $display("FAIL init_cur_addr: got %h required %h", cur_addr, m_addr());
      end
      for (int i = 0; i < 80; i++) begin
         read_mem(i, v);
         n_chk++;
         if (v !== m_mem[i]) begin
            n_fail++; $display("FAIL init_ddram[%0d]: got %h required %h", i, v, m_mem[i]);
         end
      end
   endtask

   task automatic test_data();
      logic [7:0] v;
      logic [7:0] txt [8];
      txt = '{8'h31, 8'h32, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h30, 8'h38};
      send_byte(0, 8'h80);
      for (int i = 0; i < 8; i++) send_byte(1, txt[i]);
      for (int i = 0; i < 8; i++) begin
         read_mem(i, v);
         n_chk++;
         if (v !== m_mem[i]) begin
            n_fail++; $display("FAIL data_ddram[%0d]: got %h required %h", i, v, m_mem[i]);
         end
      end
      n_chk++;
      if (cur_addr !== m_addr()) begin
         n_fail++; $display("FAIL data_cur_addr: got %h required %h", cur_addr, m_addr());
      end
   endtask

   task automatic test_wrap();
      logic [7:0] v;
      send_byte(0, 8'hA7);
      send_byte(1, 8'h41);
      send_byte(1, 8'h42);
      for (int i = 39; i <= 40; i++) begin
         read_mem(i, v);
         n_chk++;
         if (v !== m_mem[i]) begin
            n_fail++; $display("FAIL wrap_ddram[%0d]: got %h required %h", i, v, m_mem[i]);
         end
      end
      n_chk++;
      if (cur_addr !== m_addr()) begin
         n_fail++; $display("FAIL wrap_fwd_addr: got %h required %h", cur_addr, m_addr());
      end
      send_byte(0, 8'h04);
      send_byte(0, 8'h80);
      send_byte(1, 8'h5A);
      n_chk++;
      if (cur_addr !== m_addr()) begin
         n_fail++; $display("FAIL wrap_back_addr: got %h required %h", cur_addr, m_addr());
      end
      send_byte(0, 8'h06);
   endtask

   task automatic test_busy();
      logic [7:0] v;
      int e0;
      e0 = err_seen;
      send_byte(0, 8'h01);
      send_byte(1, 8'h55);
      n_chk++;
      if (err_seen - e0 != 1) begin
         n_fail++; $display("FAIL busy_err_pulses: got %0d required 1", err_seen - e0);
      end
      wait_idle();
      read_mem(0, v);
      n_chk++;
      if (v !== m_mem[0]) begin
         n_fail++; $display("FAIL busy_ddram0: got %h required %h", v, m_mem[0]);
      end
      n_chk++;
      if (cur_addr !== m_addr()) begin
         n_fail++; $display("FAIL busy_cur_addr: got %h required %h", cur_addr, m_addr());
      end
   endtask

   task automatic test_glitch();
      logic [7:0] v;
      int e0;
      int idx;
      e0 = err_seen;
      got_q.delete(); exp_q.delete();
      send_nib(1, 4'hF, 3);
      n_chk++;
      if (got_q.size() != 0) begin
         n_fail++; $display("FAIL glitch_no_byte: got %0d bytes required 0", got_q.size());
      end
      idx = m_line * 40 + m_col;
      send_byte(1, 8'h47);
      send_nib(1, 4'h4, 10);
      send_nib(1, 4'h9, int'(EN_MIN_CYC) - 1);
      send_nib(1, 4'h8, int'(EN_MIN_CYC));
      n_chk++;
      if (got_q.size() != 2 || exp_q.size() != 2) begin
         n_fail++; $display("FAIL glitch_byte_count: got %0d required 2", got_q.size());
      end else begin
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (got_q[k] !== exp_q[k]) begin
               n_fail++; $display("FAIL glitch_byte[%0d]: got %h required %h", k, got_q[k], exp_q[k]);
            end
         end
      end
      read_mem(idx, v);
      n_chk++;
      if (v !== m_mem[idx]) begin
         n_fail++; $display("FAIL glitch_ddram: got %h required %h", v, m_mem[idx]);
      end
      n_chk++;
      if (err_seen != e0) begin
         n_fail++; $display("FAIL glitch_err: got %0d pulses required 0", err_seen - e0);
      end
   endtask

   task automatic test_random();
      logic [7:0] b, v;
      logic rsb;
      int kind, exp_len;
      got_q.delete(); exp_q.delete();
      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 9);
         rsb = 1'b0;
         case (kind)
            0, 1, 2, 3: begin rsb = 1'b1; b = 8'($urandom); end
            4: b = 8'h80 | 8'($urandom_range(0, 127));
            5: b = 8'h04 | 8'($urandom_range(0, 3));
            6: b = 8'h08 | 8'($urandom_range(0, 7));
            7: b = 8'h10 | 8'($urandom_range(0, 15));
            8: b = 8'h20 | 8'($urandom_range(0, 1) * 8) | 8'($urandom_range(0, 3));
            default: b = 8'h02 | 8'($urandom_range(0, 1));
         endcase
         if ($urandom_range(0, 4) == 0)
            send_nib(1'($urandom), 4'($urandom), $urandom_range(1, EN_MIN_CYC - 1));
         busy_len = 0;
         send_byte(rsb, b);
         if (m_busy) begin
            exp_len = m_busy_len;
            wait_idle();
            n_chk++;
            if (busy_len != exp_len) begin
               n_fail++; $display("FAIL rand_busy_len: got %0d required %0d", busy_len, exp_len);
            end
         end
         n_chk++;
         if (cur_addr !== m_addr()) begin
            n_fail++;
            $display("FAIL rand_cur_addr after %h: got %h required %h", b, cur_addr, m_addr());
         end
         n_chk++;
         if ({disp_on, cursor_on, blink_on, entry_inc, entry_shift, if_4bit, two_line} !== m_modes())
         begin
            n_fail++;
            $display("FAIL rand_modes after %h: got %b required %b", b,
                     {disp_on, cursor_on, blink_on, entry_inc, entry_shift, if_4bit, two_line},
                     m_modes());
         end
      end
      n_chk++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL rand_byte_count: got %0d required %0d", got_q.size(), exp_q.size());
      end else begin
         for (int k = 0; k < exp_q.size(); k++) begin
            n_chk++;
            if (got_q[k] !== exp_q[k]) begin
               n_fail++; $display("FAIL rand_byte[%0d]: got %h required %h", k, got_q[k], exp_q[k]);
            end
         end
      end
      for (int i = 0; i < 80; i++) begin
         if (m_known[i]) begin
            read_mem(i, v);
            n_chk++;
            if (v !== m_mem[i]) begin
               n_fail++; $display("FAIL rand_ddram[%0d]: got %h required %h", i, v, m_mem[i]);
            end
         end
      end
      n_chk++;
      if (err_seen != m_err) begin
         n_fail++; $display("FAIL rand_err_count: got %0d required %0d", err_seen, m_err);
      end
   endtask

   task automatic test_reset_midbyte();
      send_nib(1, 4'h4, 10);
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      m_reset();
      n_chk++;
      if (if_4bit !== m_4bit) begin
         n_fail++; $display("FAIL midrst_if_4bit: got %b required %b", if_4bit, m_4bit);
      end
      got_q.delete(); exp_q.delete();
      send_nib(0, 4'h3, 10);
      send_nib(0, 4'h2, 10);
      n_chk++;
      if (got_q.size() != 2 || exp_q.size() != 2) begin
         n_fail++; $display("FAIL midrst_byte_count: got %0d required 2", got_q.size());
      end else begin
         n_chk++;
         if (got_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL midrst_first_byte: got %h required %h", got_q[0], exp_q[0]);
         end
      end
      n_chk++;
      if ({if_4bit, two_line} !== {m_4bit, m_2line}) begin
         n_fail++;
         $display("FAIL midrst_modes: got %b required %b", {if_4bit, two_line}, {m_4bit, m_2line});
      end
   endtask

`ifdef LCDRX_NIB_TIMEOUT_EN
   task automatic test_timeout();
      int e0;
      e0 = err_seen;
      got_q.delete(); exp_q.delete();
      send_nib(1, 4'h4, 10);
      tick(150);
      m_phase = 1;
      m_err++;
      n_chk++;
      if (err_seen - e0 != 1) begin
         n_fail++; $display("FAIL timeout_err: got %0d pulses required 1", err_seen - e0);
      end
      send_byte(1, 8'h41);
      n_chk++;
      if (got_q.size() != 1 || got_q[0] !== 9'h141) begin
         n_fail++;
         $display("FAIL timeout_next_byte: got %0d bytes first %h required 1 byte 141",
                  got_q.size(), (got_q.size() != 0) ? got_q[0] : 9'h0);
      end
   endtask
`endif

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_init();
      test_data();
      test_wrap();
      test_busy();
      test_glitch();
      test_random();
      test_reset_midbyte();
`ifdef LCDRX_NIB_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
